// File: rtl/ee201_pb_step_counter_if.sv
// Button/value bundle between the two debouncers,
// the step counter and the value consumer.
interface ee201_pb_step_counter_if #(
  parameter int WIDTH = 4
);
  logic             UP_DPB;
  logic             UP_SCEN;
  logic             UP_MCEN;
  logic             DN_DPB;
  logic             DN_SCEN;
  logic             DN_MCEN;
  logic [WIDTH-1:0] VALUE;
  logic             LIMIT;
  logic             LOCKED;

  modport master (
    output UP_DPB, UP_SCEN, UP_MCEN,
    output DN_DPB, DN_SCEN, DN_MCEN,
    input  VALUE, LIMIT, LOCKED
  );

  modport slave (
    input  UP_DPB, UP_SCEN, UP_MCEN,
    input  DN_DPB, DN_SCEN, DN_MCEN,
    output VALUE, LIMIT, LOCKED
  );
endinterface

// File: rtl/ee201_pb_step_counter.sv
// Bounded up/down value register driven by two debounced buttons,
// with auto-repeat, accelerated repeat and two-button lockout.
module ee201_pb_step_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 9,
  parameter int ACCEL_N   = 4,
  parameter int FAST_STEP = 3,
  parameter bit WRAP      = 1'b1
) (
  input logic CLK,
  input logic RESET,
  ee201_pb_step_counter_if.slave bus
);
  localparam int RW = $clog2(ACCEL_N + 1);
  localparam int AW = WIDTH + 1;
  localparam logic [AW-1:0] MAXV = AW'(MAX_VAL);
  localparam logic [AW-1:0] SPAN = AW'(MAX_VAL + 1);
  localparam logic [AW-1:0] FAST = AW'(FAST_STEP);
  localparam logic [RW-1:0] RMAX = RW'(ACCEL_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DN,
    S_LOCK
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [RW-1:0]    rcnt;
  logic [RW-1:0]    rcnt_eff;
  logic [RW-1:0]    rcnt_nx;
  logic             up_step;
  logic             dn_step;
  logic             up_go;
  logic             dn_go;
  logic             clr;
  logic [AW-1:0]    v;
  logic [AW-1:0]    s;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    dif;
  logic [WIDTH-1:0] value_nx;
  logic             limit_nx;

  assign up_step = bus.UP_SCEN | bus.UP_MCEN;
  assign dn_step = bus.DN_SCEN | bus.DN_MCEN;

  // Opposite button's level blocks the entry cycle before LOCK is registered
  assign up_go = up_step & ~dn_step & ~bus.DN_DPB
               & (state != S_LOCK);
  assign dn_go = dn_step & ~up_step & ~bus.UP_DPB
               & (state != S_LOCK);

  assign clr = (state == S_IDLE) | (state == S_LOCK)
             | bus.UP_SCEN | bus.DN_SCEN;
  assign rcnt_eff = clr ? '0 : rcnt;
  assign s   = (rcnt_eff < RMAX) ? AW'(1) : FAST;
  assign v   = {1'b0, bus.VALUE};
  assign sum = v + s;
  assign dif = v + SPAN - s;

  always_comb begin
    state_nx = state;
    if (state == S_LOCK) begin
      if (!bus.UP_DPB && !bus.DN_DPB) state_nx = S_IDLE;
    end else begin
      unique case (1'b1)
        bus.UP_DPB &  bus.DN_DPB: state_nx = S_LOCK;
        bus.UP_DPB & ~bus.DN_DPB: state_nx = S_UP;
        ~bus.UP_DPB & bus.DN_DPB: state_nx = S_DN;
        default:                  state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    value_nx = bus.VALUE;
    limit_nx = 1'b0;
    rcnt_nx  = rcnt_eff;
    if (up_go || dn_go) begin
      if (rcnt_eff != RMAX) rcnt_nx = rcnt_eff + 1'b1;
    end
    if (up_go) begin
      if (sum <= MAXV) begin
        value_nx = WIDTH'(sum);
      end else begin
        limit_nx = 1'b1;
        value_nx = WRAP ? WIDTH'(sum - SPAN) : WIDTH'(MAXV);
      end
    end else if (dn_go) begin
      if (s <= v) begin
        value_nx = WIDTH'(v - s);
      end else begin
        limit_nx = 1'b1;
        value_nx = WRAP ? WIDTH'(dif) : '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      rcnt      <= '0;
      bus.VALUE <= '0;
      bus.LIMIT <= 1'b0;
    end else begin
      state     <= state_nx;
      rcnt      <= rcnt_nx;
      bus.VALUE <= value_nx;
      bus.LIMIT <= limit_nx;
    end
  end

  assign bus.LOCKED = (state == S_LOCK);
endmodule

// File: tb/tb_ee201_pb_step_counter.sv
// Bench for ee201_pb_step_counter: wrap and saturate instances
// driven in lockstep, vector table plus random run vs a model.
module tb_ee201_pb_step_counter;
  localparam int W  = 4;
  localparam int MX = 9;
  localparam int AN = 4;
  localparam int FS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ee201_pb_step_counter_if #(.WIDTH(W)) bw ();
  ee201_pb_step_counter_if #(.WIDTH(W)) bs ();

  ee201_pb_step_counter #(
    .WIDTH(W), .MAX_VAL(MX), .ACCEL_N(AN),
    .FAST_STEP(FS), .WRAP(1'b1)
  ) u_wrap (.CLK(clk), .RESET(rst), .bus(bw));

  ee201_pb_step_counter #(
    .WIDTH(W), .MAX_VAL(MX), .ACCEL_N(AN),
    .FAST_STEP(FS), .WRAP(1'b0)
  ) u_sat (.CLK(clk), .RESET(rst), .bus(bs));

  // in = {rst, up_dpb, up_scen, up_mcen, dn_dpb, dn_scen, dn_mcen}
  typedef struct {
    logic [6:0] in;
    int vw;
    int vs;
    int lw;
    int ls;
    int lk;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int  m_vw, m_vs, m_rc;
  bit  m_lw, m_ls, m_lock, m_idle;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  task automatic drive(input logic [6:0] in);
    rst        = in[6];
    bw.UP_DPB  = in[5]; bs.UP_DPB  = in[5];
    bw.UP_SCEN = in[4]; bs.UP_SCEN = in[4];
    bw.UP_MCEN = in[3]; bs.UP_MCEN = in[3];
    bw.DN_DPB  = in[2]; bs.DN_DPB  = in[2];
    bw.DN_SCEN = in[1]; bs.DN_SCEN = in[1];
    bw.DN_MCEN = in[0]; bs.DN_MCEN = in[0];
  endtask

  task automatic step_chk(input string tag, input int vw,
                          input int vs, input int lw,
                          input int ls, input int lk);
    @(posedge clk);
    #1;
    chk({tag, " value_wrap"}, int'(bw.VALUE), vw);
    chk({tag, " value_sat"},  int'(bs.VALUE), vs);
    chk({tag, " limit_wrap"}, int'(bw.LIMIT), lw);
    chk({tag, " limit_sat"},  int'(bs.LIMIT), ls);
    chk({tag, " locked"},     int'(bw.LOCKED), lk);
    chk({tag, " locked_sat"}, int'(bs.LOCKED), lk);
  endtask

  function automatic int apply(input int v, input int s,
                               input bit up, input bit wrap,
                               output bit lim);
    lim = 1'b0;
    if (up) begin
      if (v + s <= MX) return v + s;
      lim = 1'b1;
      return wrap ? v + s - (MX + 1) : MX;
    end
    if (s <= v) return v - s;
    lim = 1'b1;
    return wrap ? v + (MX + 1) - s : 0;
  endfunction

  task automatic model(input logic [6:0] in);
    bit ud, us, um, dd, ds, dm, up, dn, ug, dg;
    int r, s;
    {ud, us, um, dd, ds, dm} = in[5:0];
    if (in[6]) begin
      m_vw = 0; m_vs = 0; m_lw = 0; m_ls = 0;
      m_lock = 0; m_idle = 1; m_rc = 0;
      return;
    end
    up = us | um;
    dn = ds | dm;
    ug = up && !dn && !dd && !m_lock;
    dg = dn && !up && !ud && !m_lock;
    r  = (m_idle || m_lock || us || ds) ? 0 : m_rc;
    s  = (r < AN) ? 1 : FS;
    m_lw = 0;
    m_ls = 0;
    if (ug || dg) begin
      m_vw = apply(m_vw, s, ug, 1'b1, m_lw);
      m_vs = apply(m_vs, s, ug, 1'b0, m_ls);
      r = (r + 1 > AN) ? AN : r + 1;
    end
    m_rc   = r;
    m_lock = m_lock ? (ud || dd) : (ud && dd);
    m_idle = !(ud || dd);
  endtask

  initial begin
    logic [6:0] in;
    bit ud, dd;
    drive(7'b1000000);

    tbl.push_back('{7'b1000000, 0, 0, 0, 0, 0});
    tbl.push_back('{7'b0100000, 0, 0, 0, 0, 0});
    tbl.push_back('{7'b0111000, 1, 1, 0, 0, 0});
    tbl.push_back('{7'b0101000, 2, 2, 0, 0, 0});
    tbl.push_back('{7'b0101000, 3, 3, 0, 0, 0});
    tbl.push_back('{7'b0101000, 4, 4, 0, 0, 0});
    tbl.push_back('{7'b0101000, 7, 7, 0, 0, 0});
    tbl.push_back('{7'b0101000, 0, 9, 1, 1, 0});
    tbl.push_back('{7'b0101000, 3, 9, 0, 1, 0});
    tbl.push_back('{7'b0100000, 3, 9, 0, 0, 0});
    tbl.push_back('{7'b0100100, 3, 9, 0, 0, 1});
    tbl.push_back('{7'b0101100, 3, 9, 0, 0, 1});
    tbl.push_back('{7'b0100101, 3, 9, 0, 0, 1});
    tbl.push_back('{7'b0000101, 3, 9, 0, 0, 1});
    tbl.push_back('{7'b0000000, 3, 9, 0, 0, 0});
    tbl.push_back('{7'b0100000, 3, 9, 0, 0, 0});
    tbl.push_back('{7'b0101000, 4, 9, 0, 1, 0});
    tbl.push_back('{7'b0000000, 4, 9, 0, 0, 0});
    tbl.push_back('{7'b1000000, 0, 0, 0, 0, 0});
    tbl.push_back('{7'b0000100, 0, 0, 0, 0, 0});
    tbl.push_back('{7'b0000111, 9, 0, 1, 1, 0});
    tbl.push_back('{7'b0000101, 8, 0, 0, 1, 0});
    tbl.push_back('{7'b0000000, 8, 0, 0, 0, 0});
    tbl.push_back('{7'b0010010, 8, 0, 0, 0, 0});
    tbl.push_back('{7'b1000000, 0, 0, 0, 0, 0});
    tbl.push_back('{7'b0100000, 0, 0, 0, 0, 0});
    tbl.push_back('{7'b0111000, 1, 1, 0, 0, 0});
    tbl.push_back('{7'b0101000, 2, 2, 0, 0, 0});
    tbl.push_back('{7'b0101000, 3, 3, 0, 0, 0});
    tbl.push_back('{7'b0101000, 4, 4, 0, 0, 0});
    tbl.push_back('{7'b0101000, 7, 7, 0, 0, 0});
    tbl.push_back('{7'b1100000, 0, 0, 0, 0, 0});
    tbl.push_back('{7'b0100000, 0, 0, 0, 0, 0});
    tbl.push_back('{7'b0101000, 1, 1, 0, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      step_chk($sformatf("row%0d", i), tbl[i].vw, tbl[i].vs,
               tbl[i].lw, tbl[i].ls, tbl[i].lk);
    end

    // both buttons and a step on the same entry cycle
    drive(7'b1000000);
    step_chk("seq_rst", 0, 0, 0, 0, 0);
    drive(7'b0101100);
    step_chk("seq_entry", 0, 0, 0, 0, 1);
    drive(7'b0101000);
    step_chk("seq_up_only", 0, 0, 0, 0, 1);
    drive(7'b0000000);
    step_chk("seq_release", 0, 0, 0, 0, 0);
    drive(7'b0000111);
    step_chk("seq_dn_press", 9, 0, 1, 1, 0);
    drive(7'b0000101);
    step_chk("seq_b2b_1", 8, 0, 0, 1, 0);
    drive(7'b0000101);
    step_chk("seq_b2b_2", 7, 0, 0, 1, 0);
    drive(7'b0000000);
    step_chk("seq_limit_drop", 7, 0, 0, 0, 0);

    ud = 0;
    dd = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) ud = ~ud;
      if ($urandom_range(7) == 0) dd = ~dd;
      in[6] = (i == 0) || ($urandom_range(99) == 0);
      in[5] = ud;
      in[4] = ($urandom_range(5) == 0);
      in[3] = ($urandom_range(2) == 0);
      in[2] = dd;
      in[1] = ($urandom_range(5) == 0);
      in[0] = ($urandom_range(2) == 0);
      drive(in);
      model(in);
      step_chk($sformatf("rnd%0d", i), m_vw, m_vs,
               int'(m_lw), int'(m_ls), int'(m_lock));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ee201_pb_step_counter.md
# ee201_pb_step_counter

Consumer of two `ee201_debouncer` instances, one for an UP push-button and one for a DOWN push-button. It converts their debounced level (DPB) and enable pulses (SCEN/MCEN) into a bounded value register. The register supports single-step, auto-repeat and accelerated repeat, with either wrap-around or saturation at the limits. It sits between the debouncers and the display/datapath logic that uses the selected value.

## Interface
- `WIDTH`, 4: width of VALUE.
- `MAX_VAL`, 9: largest legal VALUE. Range is 0..MAX_VAL. Constraint: MAX_VAL < 2^WIDTH.
- `ACCEL_N`, 4: number of steps in one hold before the step size becomes FAST_STEP.
- `FAST_STEP`, 3: accelerated step size. Constraint: 1 <= FAST_STEP <= MAX_VAL.
- `WRAP`, 1: 1 = modulo (MAX_VAL+1) arithmetic; 0 = saturate at 0 / MAX_VAL.
- `CLK` input 1: system clock. Single clock domain, same clock as the debouncers.
- `RESET` input 1: synchronous, active-high reset.
- `UP_DPB` input 1: debounced UP level.
- `UP_SCEN` input 1: UP single-cycle enable, one pulse per press.
- `UP_MCEN` input 1: UP multi-cycle enable, first pulse at press, then repeat pulses while held.
- `DN_DPB`, `DN_SCEN`, `DN_MCEN` input 1 each: same meanings for DOWN.
- `VALUE` output WIDTH: current value, registered.
- `LIMIT` output 1: one-cycle pulse; an applied step wrapped or was clamped.
- `LOCKED` output 1: level; high while in state LOCK.

## Operation
- Step request per button: `x_step = x_SCEN | x_MCEN`. At most one step per button per cycle; coincident SCEN and MCEN count once.
- FSM states: IDLE, UP, DN, LOCK. State register resets to IDLE.
- From IDLE or UP or DN:
  - UP_DPB & DN_DPB -> LOCK.
  - else UP_DPB -> UP.
  - else DN_DPB -> DN.
  - else -> IDLE.
- LOCK -> IDLE only when UP_DPB = 0 and DN_DPB = 0 in the same cycle. Otherwise stay in LOCK.
- Step gating:
  - An UP step is applied when UP_step = 1, DN_DPB = 0, and the current state is not LOCK.
  - A DOWN step is applied symmetrically.
  - If both steps arrive in the same cycle, neither is applied.
- Repeat counter `rcnt`:
  - Width: ceil(log2(ACCEL_N+1)).
  - Cleared by RESET, in IDLE, in LOCK, and by any x_SCEN.
  - Incremented on each applied step; saturates at ACCEL_N.
  - Step size s = 1 if rcnt (before increment) < ACCEL_N, else FAST_STEP.
  - A SCEN step always uses s = 1, because SCEN clears rcnt.
- Arithmetic uses a WIDTH+1-bit intermediate.
- UP step:
  - If v+s <= MAX_VAL: v+s.
  - Else with WRAP=1: v+s-(MAX_VAL+1), and LIMIT=1.
  - Else with WRAP=0: MAX_VAL, and LIMIT=1.
- DOWN step:
  - If s <= v: v-s.
  - Else with WRAP=1: v+(MAX_VAL+1)-s, and LIMIT=1.
  - Else with WRAP=0: 0, and LIMIT=1.
- Saturating at an exact limit (e.g. UP at MAX_VAL with WRAP=0) leaves VALUE unchanged and still pulses LIMIT.
- A step landing exactly on MAX_VAL or 0 does not pulse LIMIT.

## Timing
- Reset values: VALUE=0, LIMIT=0, LOCKED=0, state=IDLE, rcnt=0.
- RESET has priority over all inputs. Asserting it mid-hold returns everything to reset values at the next edge.
  - Steps after RESET deassertion restart at s=1.
  - If a button is still held, the FSM re-enters UP/DN from its DPB level on the following edge.
- Latency:
  - A step sampled at edge k appears on VALUE after edge k, i.e. 1 cycle.
  - LIMIT is high for exactly the cycle following that edge.
- LOCKED follows the state register: it rises 1 cycle after both DPB are sampled high, and falls 1 cycle after both are sampled low.
- LOCK blocks steps from the cycle the state register holds LOCK. Steps are also blocked combinationally on the entry cycle via the DPB gating above.
- No handshake: every applied step is consumed in one cycle. Back-to-back MCEN pulses on consecutive cycles each apply.

## Test plan
(Parameters WIDTH=4, MAX_VAL=9, ACCEL_N=4, FAST_STEP=3.)
- Single press: from VALUE=0, UP_DPB=1, then one cycle of UP_SCEN=UP_MCEN=1 -> VALUE=1 after the next edge, LIMIT=0, state UP.
- Accelerated hold, WRAP=1: UP held, SCEN pulse plus 5 further MCEN pulses -> VALUE sequence 1,2,3,4,7,0. LIMIT pulses only on the 7->0 step.
- Saturation, WRAP=0: same stimulus as the previous scenario -> VALUE sequence 1,2,3,4,7,9 with LIMIT on the last step. One more MCEN -> VALUE stays 9 and LIMIT pulses.
- Down wrap: from VALUE=0, one DN press -> 9 with WRAP=1, or 0 with WRAP=0; LIMIT pulses in both cases.
- Lockout: UP held, then DN_DPB=1 -> LOCKED=1. MCEN pulses on either button leave VALUE unchanged. Releasing only UP keeps LOCKED=1. Releasing both -> LOCKED=0 next cycle, and the next UP press gives s=1.
- Reset mid-hold: VALUE=7 with rcnt saturated and UP still held. Pulse RESET one cycle -> VALUE=0, LIMIT=0, state UP one cycle after release, next MCEN gives VALUE=1.
